tt_um_cnt_checker: RTL and testbench
====================================

# tt_um_cnt_checker

Counter-stream checker: receives the 8-bit free-running incrementing count that our power-test pattern source drives onto a pad bus, locks onto it, and counts mismatches. It is the receive end of that link and lives as a standalone user tile in the same Tiny Tapeout wrapper. Error count, lock status and the expected value are read back on `uo_out` through a select field on `uio_in`.

## Interface
- `LOCK_CNT`, default 4: consecutive matches needed to enter LOCKED. Legal range 1..15.
- `LOSS_CNT`, default 4: consecutive mismatches needed to drop from LOCKED to HUNT. Legal range 1..15.

- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: tile enable. When low, all state holds and outputs keep being driven.
- `ui_in` input 8: received count stream.
- `uio_in` input 8: control inputs.
  - [0] clr: clear error counter and sticky flags.
  - [2:1] sel: read-back select.
  - [7:3] ignored.
- `uo_out` output 8: registered read-back byte.
- `uio_out` output 8: live status.
  - [7] locked.
  - [6] lost_sticky.
  - [5] mismatch (registered one-cycle pulse).
  - [4] ever_locked.
  - [3:0] = 0.
- `uio_oe` output 8: constant 8'hF0.

## Operation
- Internal reset `rst_n_i`: one flop, asynchronously cleared by `rst_n`, set to 1 on the first clk edge after release. All other registers reset asynchronously on `rst_n_i` low.
- Reset values: `uo_out` = 0, `uio_out` = 0, `d_q` = 0, `exp` = 0, `prev_valid` = 0, `run` = 0, `err_cnt` = 0, `shadow` = 0, all flags = 0, state = HUNT.
- Input stage: `d_q <= ui_in` every enabled cycle. `clr_q <= uio_in[0]`.
- Compare: `hit = (d_q == exp)`. Arithmetic is 8-bit modulo, so 0xFF followed by 0x00 is a match.
- HUNT:
  - `exp <= d_q + 1` and `prev_valid <= 1` every cycle.
  - Compare counts only when `prev_valid` is 1. `hit` increments `run`; a miss clears `run`.
  - When the LOCK_CNT-th consecutive hit occurs: go to LOCKED, clear `run`, set ever_locked.
  - HUNT never increments `err_cnt`.
- LOCKED:
  - `exp <= exp + 1` (free-running, no resync to the input).
  - Miss: `err_cnt` +1, saturating at 0xFFFF; `run` +1; mismatch pulse = 1.
  - Hit: `run` cleared.
  - When the LOSS_CNT-th consecutive miss occurs: go to HUNT, clear `run` and `prev_valid`, set lost_sticky.
- Clear: `clr_q` = 1 zeroes `err_cnt`, lost_sticky and ever_locked. Clear wins over a same-cycle increment. State, `run` and `exp` are not affected.
- Read-back, registered: `uo_out <= f(sel)`.
  - 00: `err_cnt[7:0]`.
  - 01: `err_cnt[15:8]` (or `shadow`, see Configuration).
  - 10: `{locked, lost_sticky, ever_locked, 1'b0, run[3:0]}`.
  - 11: `exp`.
- `ena` low: no register updates, including `d_q` and the output registers.
- `rst_n` low at any time, including mid-lock: every register returns to its reset value. After release, locking restarts from HUNT.

## Timing
- A word captured into `d_q` at edge k is compared at edge k+1. State, `run`, `err_cnt` and `uio_out` change at edge k+1; `uo_out` reflects the change at edge k+2.
- Minimum lock time from the first valid sample: LOCK_CNT+1 edges after the first capture.
- `clr` sampled at edge k takes effect at edge k+1 and is visible on `uo_out` at edge k+2.
- `sel` change is visible on `uo_out` after one edge.

## Configuration
- Macro: `CNT_CHECK_SNAPSHOT_EN`.
- Defined: `shadow <= err_cnt[15:8]` on every enabled cycle where sel = 00, and holds otherwise. sel = 01 returns `shadow`, giving a coherent 16-bit read (low byte first, then high byte).
- Undefined: there is no `shadow` register, and sel = 01 returns the live `err_cnt[15:8]`.

## Test plan
- Lock: reset, then drive 0x10, 0x11, 0x12, … one per cycle.
  - locked = 1 no later than 6 edges after the first capture.
  - ever_locked = 1, `err_cnt` = 0, `uio_oe` = 0xF0.
- Wrap: while locked, drive 0xFD, 0xFE, 0xFF, 0x00, 0x01 → `err_cnt` stays 0, locked stays 1.
- Glitch: while locked on 0x40…, replace 0x45 with 0x00, then continue with 0x46.
  - `err_cnt` = 1, one mismatch pulse, locked stays 1.
  - sel = 10 shows run = 0 after 0x46.
- Loss and relock: while locked, hold 0xAA for 4 cycles.
  - `err_cnt` = 4, locked = 0, lost_sticky = 1.
  - Resume counting: relocks, lost_sticky stays 1 until clr pulses, then reads 0.
- Clear collision and reset: assert clr on the same cycle as a locked mismatch.
  - `err_cnt` = 0.
  - Then pull `rst_n` low mid-lock: `uo_out`, `uio_out` and all counters = 0, state = HUNT.
- Snapshot: reach `err_cnt` = 0x00FF, read sel = 00 (0xFF), inject one more error, then read sel = 01.
  - Macro defined → 0x00.
  - Macro undefined → 0x01.

Source files
------------

// File: rtl/tt_um_cnt_checker.sv
// tt_um_cnt_checker
//
// Receive-side checker for the free-running 8-bit incrementing count driven by
// the power-test pattern source. It hunts for the count, locks once it has seen
// LOCK_CNT consecutive correct increments, then free-runs its own expected
// value and counts every mismatch. LOSS_CNT consecutive mismatches drop it back
// to hunting.
//
// Parameters
//   LOCK_CNT  consecutive hits needed to lock         (legal 1..15)
//   LOSS_CNT  consecutive misses needed to drop lock  (legal 1..15)
//
// Optional feature macro: CNT_CHECK_SNAPSHOT_EN
//   Defined   : the high error byte is snapshotted whenever sel = 00, so a
//               low-then-high read pair is coherent.
//   Undefined : sel = 01 returns the live high error byte.
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable; low freezes every register (outputs stay driven)
//   ui_in    received count stream
//   uio_in   [0] clr (clear error count + sticky flags), [2:1] sel, [7:3] unused
//   uo_out   registered read-back byte selected by sel:
//              00 err_cnt[7:0]   01 err_cnt[15:8] / snapshot
//              10 {locked, lost_sticky, ever_locked, 0, run[3:0]}   11 exp
//   uio_out  {locked, lost_sticky, mismatch, ever_locked, 4'b0}
//   uio_oe   constant 8'hF0 (upper nibble of uio is output)

module tt_um_cnt_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Run-length compare values: the Nth consecutive event is seen while run
  // still holds N-1.
  localparam logic [3:0] LockLast = 4'(LOCK_CNT - 1);
  localparam logic [3:0] LossLast = 4'(LOSS_CNT - 1);

  typedef enum logic [0:0] {
    StHunt,
    StLocked
  } state_e;

  // ---------------------------------------------------------------------------
  // Internal reset: cleared asynchronously, released on the first clock edge
  // after rst_n rises so every other flop leaves reset synchronously.
  // ---------------------------------------------------------------------------
  logic rst_n_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_n_i <= 1'b0;
    end else begin
      rst_n_i <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [7:0]  d_q;
  logic        clr_q;
  logic [7:0]  exp_q, exp_d;
  logic        prev_valid_q, prev_valid_d;
  logic [3:0]  run_q, run_d;
  logic [15:0] err_q, err_d;
  logic        lost_q, lost_d;
  logic        ever_q, ever_d;
  logic        mismatch_q, mismatch_d;
  logic [7:0]  uo_q, uo_d;

  logic [1:0]  sel;
  logic        hit;
  logic        locked;
  logic [7:0]  err_hi_rd;

  assign sel    = uio_in[2:1];
  assign hit    = (d_q == exp_q);
  assign locked = (state_q == StLocked);

  // Bits [7:3] of uio_in carry no function.
  logic unused_uio;
  assign unused_uio = ^uio_in[7:3];

  // ---------------------------------------------------------------------------
  // Lock / error tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    prev_valid_d = prev_valid_q;
    run_d        = run_q;
    err_d        = err_q;
    lost_d       = lost_q;
    ever_d       = ever_q;
    mismatch_d   = 1'b0;

    unique case (state_q)
      StHunt: begin
        // Predict from the received word; the first word after entry has no
        // predecessor, so it is not compared.
        exp_d        = d_q + 8'd1;
        prev_valid_d = 1'b1;
        if (prev_valid_q) begin
          if (hit) begin
            if (run_q == LockLast) begin
              state_d = StLocked;
              run_d   = 4'd0;
              ever_d  = 1'b1;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            run_d = 4'd0;
          end
        end
      end

      StLocked: begin
        // Free-running: a corrupted word must not drag the reference with it.
        exp_d = exp_q + 8'd1;
        if (hit) begin
          run_d = 4'd0;
        end else begin
          mismatch_d = 1'b1;
          if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end
          if (run_q == LossLast) begin
            state_d      = StHunt;
            run_d        = 4'd0;
            prev_valid_d = 1'b0;
            lost_d       = 1'b1;
          end else begin
            run_d = run_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = StHunt;
      end
    endcase

    // Clear has priority over any same-cycle update of these fields.
    if (clr_q) begin
      err_d  = 16'd0;
      lost_d = 1'b0;
      ever_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional coherent high-byte snapshot
  // ---------------------------------------------------------------------------
`ifdef CNT_CHECK_SNAPSHOT_EN
  logic [7:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (sel == 2'b00) begin
      shadow_d = err_q[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q <= 8'd0;
    end else if (ena) begin
      shadow_q <= shadow_d;
    end
  end

  assign err_hi_rd = shadow_q;
`else
  assign err_hi_rd = err_q[15:8];
`endif

  // ---------------------------------------------------------------------------
  // Read-back mux
  // ---------------------------------------------------------------------------
  always_comb begin
    uo_d = 8'd0;
    unique case (sel)
      2'b00:   uo_d = err_q[7:0];
      2'b01:   uo_d = err_hi_rd;
      2'b10:   uo_d = {locked, lost_q, ever_q, 1'b0, run_q};
      2'b11:   uo_d = exp_q;
      default: uo_d = 8'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StHunt;
      d_q          <= 8'd0;
      clr_q        <= 1'b0;
      exp_q        <= 8'd0;
      prev_valid_q <= 1'b0;
      run_q        <= 4'd0;
      err_q        <= 16'd0;
      lost_q       <= 1'b0;
      ever_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      uo_q         <= 8'd0;
    end else if (ena) begin
      state_q      <= state_d;
      d_q          <= ui_in;
      clr_q        <= uio_in[0];
      exp_q        <= exp_d;
      prev_valid_q <= prev_valid_d;
      run_q        <= run_d;
      err_q        <= err_d;
      lost_q       <= lost_d;
      ever_q       <= ever_d;
      mismatch_q   <= mismatch_d;
      uo_q         <= uo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign uo_out  = uo_q;
  assign uio_out = {locked, lost_q, mismatch_q, ever_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_cnt_checker.sv
// Bench for tt_um_cnt_checker (LOCK_CNT = LOSS_CNT = 4). Read-back expectations
// are queued when the read is launched and popped once uo_out has been updated.

module tb_tt_um_cnt_checker;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] nxt;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];

  tt_um_cnt_checker #(
    .LOCK_CNT(4),
    .LOSS_CNT(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] b);
    ui_in = b;
    step();
  endtask

  task automatic send_run(input int n);
    for (int i = 0; i < n; i++) begin
      ui_in = nxt;
      nxt   = nxt + 8'd1;
      step();
    end
  endtask

  task automatic push_exp(input string name, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'hA8;  // junk in ignored bits, clr = 0, sel = 00
    #12;
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_uo_out: got %h want %h", uo_out, 8'h00);
    end
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_uio_out: got %h want %h", uio_out, 8'h00);
    end
    n_checks++;
    if (uio_oe !== 8'hF0) begin
      n_fail++;
      $display("FAIL reset_uio_oe: got %h want %h", uio_oe, 8'hF0);
    end
    rst_n = 1'b1;
    step();  // internal reset releases here
  endtask

  task automatic test_lock();
    int   edges;
    exp_t e;
    nxt = 8'h10;
    send_run(1);  // first capture
    edges = 0;
    while (!uio_out[7] && edges < 10) begin
      send_run(1);
      edges++;
    end
    n_checks++;
    if (edges != 5) begin
      n_fail++;
      $display("FAIL lock_latency: got %0d edges want %0d", edges, 5);
    end
    n_checks++;
    if (uio_out !== 8'h90) begin
      n_fail++;
      $display("FAIL lock_status: got %h want %h", uio_out, 8'h90);
    end
    uio_in[2:1] = 2'b00;
    push_exp("lock_err_lo", 8'h00);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
    n_checks++;
    if (uio_oe !== 8'hF0) begin
      n_fail++;
      $display("FAIL lock_uio_oe: got %h want %h", uio_oe, 8'hF0);
    end
  endtask

  task automatic test_ena_hold();
    logic [7:0] uo_before;
    uo_before = uo_out;
    ena       = 1'b0;
    for (int i = 0; i < 3; i++) send_word(8'h33);
    n_checks++;
    if (uio_out !== 8'h90 || uo_out !== uo_before) begin
      n_fail++;
      $display("FAIL ena_hold: got uio %h uo %h want uio %h uo %h",
               uio_out, uo_out, 8'h90, uo_before);
    end
    ena = 1'b1;
  endtask

  task automatic test_wrap();
    exp_t e;
    while (nxt != 8'hFD) send_run(1);
    send_run(5);  // FD FE FF 00 01
    send_run(2);
    uio_in[2:1] = 2'b00;
    push_exp("wrap_err_lo", 8'h00);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
    n_checks++;
    if (uio_out[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_locked: got %b want %b", uio_out[7], 1'b1);
    end
  endtask

  task automatic test_glitch();
    int   pulses;
    exp_t e;
    while (nxt != 8'h45) send_run(1);
    send_word(8'h00);
    nxt    = 8'h46;
    pulses = int'(uio_out[5]);
    for (int i = 0; i < 3; i++) begin
      send_run(1);
      pulses += int'(uio_out[5]);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d want %0d", pulses, 1);
    end
    n_checks++;
    if (uio_out[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_locked: got %b want %b", uio_out[7], 1'b1);
    end
    uio_in[2:1] = 2'b10;
    push_exp("glitch_status_run", 8'hA0);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
    uio_in[2:1] = 2'b00;
    push_exp("glitch_err_lo", 8'h01);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
  endtask

  task automatic test_loss_relock();
    int   edges;
    exp_t e;
    uio_in[0] = 1'b1;
    send_run(1);
    uio_in[0] = 1'b0;
    send_run(2);
    for (int i = 0; i < 4; i++) send_word(8'hAA);
    n_checks++;
    if (uio_out[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_three_misses_locked: got %b want %b", uio_out[7], 1'b1);
    end
    send_run(1);  // fourth miss is judged here
    n_checks++;
    if (uio_out[7:6] !== 2'b01) begin
      n_fail++;
      $display("FAIL loss_status: got %b want %b", uio_out[7:6], 2'b01);
    end
    uio_in[2:1] = 2'b00;
    push_exp("loss_err_lo", 8'h04);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
    edges = 0;
    while (!uio_out[7] && edges < 12) begin
      send_run(1);
      edges++;
    end
    n_checks++;
    if (uio_out[7:6] !== 2'b11) begin
      n_fail++;
      $display("FAIL relock_status: got %b want %b", uio_out[7:6], 2'b11);
    end
    uio_in[0] = 1'b1;
    send_run(1);
    uio_in[0] = 1'b0;
    send_run(1);
    n_checks++;
    if (uio_out[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_lost_sticky: got %b want %b", uio_out[6], 1'b0);
    end
    uio_in[2:1] = 2'b10;
    push_exp("clr_status", 8'h80);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
  endtask

  task automatic test_clear_collision_reset();
    exp_t e;
    uio_in[0] = 1'b1;
    send_word(nxt ^ 8'h5A);
    nxt       = nxt + 8'd1;
    uio_in[0] = 1'b0;
    send_run(2);
    uio_in[2:1] = 2'b00;
    push_exp("collision_err_lo", 8'h00);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
    uio_in[2:1] = 2'b11;
    send_run(1);  // uo_out now shows a non-zero exp
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midlock_reset: got uo %h uio %h want uo %h uio %h",
               uo_out, uio_out, 8'h00, 8'h00);
    end
    step();
    rst_n = 1'b1;
    step();
    uio_in[2:1] = 2'b11;
    push_exp("post_reset_exp", 8'h00);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
    uio_in[2:1] = 2'b10;
    push_exp("post_reset_status", 8'h00);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val || uio_out[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got %h locked %b want %h locked 0",
               e.name, uo_out, uio_out[7], e.val);
    end
  endtask

  task automatic test_snapshot();
    int   edges;
    exp_t e;
    edges = 0;
    while (!uio_out[7] && edges < 12) begin
      send_run(1);
      edges++;
    end
    n_checks++;
    if (uio_out[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL snap_lock: got %b want %b", uio_out[7], 1'b1);
    end
    uio_in[2:1] = 2'b00;
    for (int i = 0; i < 255; i++) begin
      send_word(nxt ^ 8'h80);
      nxt = nxt + 8'd1;
      send_run(1);
    end
    send_run(1);
    push_exp("snap_err_lo", 8'hFF);
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
    uio_in[2:1] = 2'b01;
    send_run(1);
    send_word(nxt ^ 8'h80);
    nxt = nxt + 8'd1;
    send_run(2);
`ifdef CNT_CHECK_SNAPSHOT_EN
    push_exp("snap_err_hi", 8'h00);
`else
    push_exp("snap_err_hi", 8'h01);
`endif
    send_run(1);
    e = sb_q.pop_front();
    n_checks++;
    if (uo_out !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, uo_out, e.val);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_ena_hold();
    test_wrap();
    test_glitch();
    test_loss_relock();
    test_clear_collision_reset();
    test_snapshot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
